// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: parity modes and framer state encoding.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // The reserved mode 2'b11 falls through to "no parity bit".
    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// Data shift register, bit counter and word parity for the UART framer.
// Strobes come from the framer FSM; this block makes no sequencing decisions.
module uart_tx_shifter #(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 clr_cnt_i,
    input  logic                 shift_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 cur_bit_o,
    output logic                 next_bit_o,
    output logic                 last_bit_o,
    output logic                 parity_o
);

    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 par_q, par_d;

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        if (load_i) begin
            shift_d = data_i;
            par_d   = ^data_i;
        end else if (shift_i) begin
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        if (clr_cnt_i) begin
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
        end
    end

    assign cur_bit_o  = shift_q[0];
    assign next_bit_o = shift_q[1];
    assign last_bit_o = (bit_cnt_q == CNT_W'(DATA_BITS - 1));
    assign parity_o   = par_q;

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: one-word holding register, config latch, frame FSM and registered tx.
// state | meaning: IDLE line high | START start bit | DATA data bits | PARITY parity bit | STOP stop bit(s)
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_clk_en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 frame_done
);

    state_e               state_q, state_d;
    logic                 tx_q, tx_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
    logic [1:0]           par_mode_q, par_mode_d;
    logic                 stop2_q, stop2_d;
    logic                 stop_cnt_q, stop_cnt_d;

    logic load, clr_cnt, shift, done, accept;
    logic cur_bit, next_bit, last_bit, word_par;

    uart_tx_shifter #(
        .DATA_BITS (DATA_BITS),
        .CNT_W     (CNT_W)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .clr_cnt_i  (clr_cnt),
        .shift_i    (shift),
        .data_i     (hold_data_q),
        .cur_bit_o  (cur_bit),
        .next_bit_o (next_bit),
        .last_bit_o (last_bit),
        .parity_o   (word_par)
    );

    assign in_ready = ~hold_valid_q & ~rst;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        stop_cnt_d = stop_cnt_q;
        load       = 1'b0;
        clr_cnt    = 1'b0;
        shift      = 1'b0;
        done       = 1'b0;
        if (tx_clk_en) begin
            unique case (state_q)
                ST_IDLE: begin
                    tx_d = 1'b1;
                    if (hold_valid_q) begin
                        state_d = ST_START;
                        tx_d    = 1'b0;
                        load    = 1'b1;
                    end
                end
                ST_START: begin
                    state_d = ST_DATA;
                    tx_d    = cur_bit;
                    clr_cnt = 1'b1;
                end
                ST_DATA: begin
                    if (!last_bit) begin
                        shift = 1'b1;
                        tx_d  = next_bit;
                    end else if (par_enabled(par_mode_q)) begin
                        state_d = ST_PARITY;
                        tx_d    = (par_mode_q == PAR_ODD) ? ~word_par : word_par;
                    end else begin
                        state_d    = ST_STOP;
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                    end
                end
                ST_PARITY: begin
                    state_d    = ST_STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
                ST_STOP: begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        done = 1'b1;
                        // A held word chains straight into its start bit.
                        if (hold_valid_q) begin
                            state_d = ST_START;
                            tx_d    = 1'b0;
                            load    = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            tx_d    = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        par_mode_d   = par_mode_q;
        stop2_d      = stop2_q;
        if (accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = data_in;
        end else if (load) begin
            hold_valid_d = 1'b0;
        end
        if (load) begin
            par_mode_d = cfg_parity;
            stop2_d    = cfg_stop2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tx_q         <= 1'b1;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            par_mode_q   <= PAR_NONE;
            stop2_q      <= 1'b0;
            stop_cnt_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_q         <= tx_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            par_mode_q   <= par_mode_d;
            stop2_q      <= stop2_d;
            stop_cnt_q   <= stop_cnt_d;
        end
    end

    assign tx         = tx_q;
    assign tx_busy    = (state_q != ST_IDLE) | hold_valid_q;
    assign frame_done = done & ~rst;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer: scoreboard monitor plus table-driven and hand-written sequences.
module tb_uart_tx_framer;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst, tx_clk_en, in_valid, cfg_stop2;
    logic [7:0] data_in;
    logic [1:0] cfg_parity;
    logic       in_ready, tx, tx_busy, frame_done;

    logic       in_valid7;
    logic [6:0] data7;
    logic [1:0] cfg_par7;
    logic       cfg_stop7;
    logic       in_ready7, tx7, busy7, done7;

    always #5 clk = ~clk;

    uart_tx_framer #(.DATA_BITS(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .tx_clk_en(tx_clk_en), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .tx(tx), .tx_busy(tx_busy), .frame_done(frame_done)
    );

    uart_tx_framer #(.DATA_BITS(7), .CNT_W(4)) dut7 (
        .clk(clk), .rst(rst), .tx_clk_en(tx_clk_en), .in_valid(in_valid7), .in_ready(in_ready7),
        .data_in(data7), .cfg_parity(cfg_par7), .cfg_stop2(cfg_stop7),
        .tx(tx7), .tx_busy(busy7), .frame_done(done7)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic [1:0] par;
        logic       stop2;
    } word_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] par;
        logic       stop2;
        int         exp_len;
        logic       exp_pbit;
    } vec_t;

    word_t      src_q[$];
    logic [7:0] sb_q[$];
    logic       last_done, last_done7;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: present the head word of src_q, record acceptance into the scoreboard.
    task automatic step(input logic tick);
        logic acc;
        tx_clk_en = tick;
        if (src_q.size() > 0) begin
            in_valid   = 1'b1;
            data_in    = src_q[0].data;
            cfg_parity = src_q[0].par;
            cfg_stop2  = src_q[0].stop2;
        end else begin
            in_valid = 1'b0;
            data_in  = 8'($urandom);
        end
        @(negedge clk);
        acc        = in_valid && in_ready;
        last_done  = frame_done;
        last_done7 = done7;
        @(posedge clk);
        if (acc) begin
            sb_q.push_back(src_q[0].data);
            void'(src_q.pop_front());
        end
        #1;
    endtask

    task automatic push_wait(input logic [7:0] d, input logic [1:0] p, input logic s);
        word_t w;
        w.data = d; w.par = p; w.stop2 = s;
        src_q.push_back(w);
        for (int k = 0; k < 50 && src_q.size() != 0; k++) step(1'b0);
        chk("accept_timeout", src_q.size(), 0);
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 300 && (tx_busy || src_q.size() != 0); k++) step(1'b1);
        chk("drain_timeout", tx_busy, 1'b0);
    endtask

    // Monitor: on each tick, check frame_done and the serial bits against a model built
    // from the scoreboard word and the config present at the tick that started the frame.
    initial begin
        logic        in_frame;
        int          idx, len;
        logic [15:0] ebits;
        logic [1:0]  sp;
        logic        s2, pe;
        logic [7:0]  d;
        in_frame = 1'b0; idx = 0; len = 0; ebits = '1;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 1'b0;
                sb_q.delete();
            end else if (tx_clk_en) begin
                sp = cfg_parity;
                s2 = cfg_stop2;
                chk("mon_frame_done", frame_done, (in_frame && idx == len));
                if (in_frame && idx == len) in_frame = 1'b0;
                @(posedge clk);
                #1;
                if (in_frame) begin
                    chk("mon_frame_bit", tx, ebits[idx]);
                    idx++;
                end else if (tx == 1'b0) begin
                    chk("mon_sb_nonempty", sb_q.size() != 0, 1'b1);
                    if (sb_q.size() != 0) begin
                        d  = sb_q.pop_front();
                        pe = (sp == PAR_EVEN) || (sp == PAR_ODD);
                        ebits = '1;
                        ebits[0] = 1'b0;
                        for (int i = 0; i < 8; i++) ebits[1+i] = d[i];
                        if (pe) ebits[9] = (^d) ^ (sp == PAR_ODD);
                        len = 9 + (pe ? 1 : 0) + (s2 ? 2 : 1);
                        in_frame = 1'b1;
                        idx = 1;
                    end
                end
            end
        end
    end

    initial begin
        vec_t        vecs[8];
        logic        e1[10];
        logic        e7[10];
        logic        e4[20];
        logic [19:0] got;
        logic [7:0]  gotd;
        int          n;
        logic        done_seen;

        vecs[0] = '{8'hA5, PAR_NONE, 1'b0, 10, 1'b0};
        vecs[1] = '{8'hA5, PAR_EVEN, 1'b0, 11, 1'b0};
        vecs[2] = '{8'h41, PAR_ODD,  1'b0, 11, 1'b1};
        vecs[3] = '{8'h41, PAR_EVEN, 1'b1, 12, 1'b0};
        vecs[4] = '{8'hFF, PAR_ODD,  1'b1, 12, 1'b1};
        vecs[5] = '{8'h00, 2'b11,    1'b0, 10, 1'b0};
        vecs[6] = '{8'h80, PAR_EVEN, 1'b1, 12, 1'b1};
        vecs[7] = '{8'h3C, PAR_ODD,  1'b0, 11, 1'b1};
        e1 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        e7 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        e4 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; tx_clk_en = 1'b0; in_valid = 1'b0; data_in = '0;
        cfg_parity = PAR_NONE; cfg_stop2 = 1'b0;
        in_valid7 = 1'b0; data7 = '0; cfg_par7 = PAR_NONE; cfg_stop7 = 1'b1;
        last_done = 1'b0; last_done7 = 1'b0;

        // Reset state, with ticks during reset ignored
        repeat (3) step(1'b1);
        chk("rst_tx", tx, 1'b1);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_tx_busy", tx_busy, 1'b0);
        chk("rst_frame_done", last_done, 1'b0);
        rst = 1'b0;
        step(1'b0);
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_tx", tx, 1'b1);

        // 8N1 0xA5
        push_wait(8'hA5, PAR_NONE, 1'b0);
        chk("t1_busy_held", tx_busy, 1'b1);
        chk("t1_ready_full", in_ready, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b1);
            chk("t1_bit", tx, e1[k]);
            chk("t1_no_done", last_done, 1'b0);
        end
        step(1'b1);
        chk("t1_frame_done", last_done, 1'b1);
        chk("t1_busy_after", tx_busy, 1'b0);

        // Tick coinciding with acceptance must not start the frame
        begin
            word_t w;
            w.data = 8'h96; w.par = PAR_NONE; w.stop2 = 1'b0;
            src_q.push_back(w);
            step(1'b1);
            chk("lat_accepted", src_q.size(), 0);
            chk("lat_no_start", tx, 1'b1);
            chk("lat_busy", tx_busy, 1'b1);
            step(1'b1);
            chk("lat_start", tx, 1'b0);
            drain();
        end

        // Table: parity modes, stop bits, frame length
        for (int v = 0; v < 8; v++) begin
            push_wait(vecs[v].data, vecs[v].par, vecs[v].stop2);
            got = '1; n = 0; done_seen = 1'b0;
            for (int k = 0; k < 20 && !done_seen; k++) begin
                step(1'b1);
                if (last_done) done_seen = 1'b1;
                else begin
                    got[n] = tx;
                    n++;
                end
            end
            chk("tbl_done_seen", done_seen, 1'b1);
            chk("tbl_len", n, vecs[v].exp_len);
            chk("tbl_start", got[0], 1'b0);
            for (int i = 0; i < 8; i++) gotd[i] = got[1+i];
            chk("tbl_data", gotd, vecs[v].data);
            if (vecs[v].exp_len == 11 || (vecs[v].exp_len == 12 && vecs[v].stop2 == 1'b1 && vecs[v].par != PAR_NONE))
                chk("tbl_pbit", got[9], vecs[v].exp_pbit);
            chk("tbl_stop", got[n-1], 1'b1);
            chk("tbl_idle_busy", tx_busy, 1'b0);
        end

        // DATA_BITS=7 instance, two stop bits, 0x41
        in_valid7 = 1'b1; data7 = 7'h41;
        step(1'b0);
        in_valid7 = 1'b0;
        chk("d7_busy", busy7, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step(1'b1);
            chk("d7_bit", tx7, e7[k]);
        end
        step(1'b1);
        chk("d7_frame_done", last_done7, 1'b1);
        chk("d7_busy_after", busy7, 1'b0);

        // Back-to-back 0x55 then 0xAA, no idle tick between frames
        begin
            word_t w;
            w.data = 8'h55; w.par = PAR_NONE; w.stop2 = 1'b0;
            src_q.push_back(w);
            w.data = 8'hAA;
            src_q.push_back(w);
            step(1'b0);
            step(1'b0);
            chk("b2b_hold_full", src_q.size(), 1);
            for (int k = 0; k < 20; k++) begin
                step(1'b1);
                if (k == 4) chk("b2b_second_accepted", src_q.size(), 0);
                chk("b2b_bit", tx, e4[k]);
            end
            step(1'b1);
            chk("b2b_done", last_done, 1'b1);
            chk("b2b_idle", tx_busy, 1'b0);
        end

        // Back-pressure, in_ready timing and mid-frame config changes
        begin
            word_t w;
            w.data = 8'hC3; w.par = PAR_EVEN; w.stop2 = 1'b0;
            src_q.push_back(w);
            step(1'b0);
            chk("bp_first_taken", src_q.size(), 0);
            chk("bp_ready_low", in_ready, 1'b0);
            w.data = 8'h5A; w.par = PAR_ODD; w.stop2 = 1'b1;
            src_q.push_back(w);
            step(1'b0);
            step(1'b0);
            chk("bp_not_taken", src_q.size(), 1);
            chk("bp_ready_still_low", in_ready, 1'b0);
            step(1'b1);
            chk("bp_ready_after_load", in_ready, 1'b1);
            step(1'b0);
            chk("bp_second_taken", src_q.size(), 0);
            chk("bp_ready_full_frame", in_ready, 1'b0);
            repeat (3) step(1'b1);
            cfg_parity = PAR_NONE; cfg_stop2 = 1'b0;
            repeat (2) step(1'b1);
            chk("bp_ready_mid_frame", in_ready, 1'b0);
            drain();
        end

        // Reset during the 4th data bit, then recovery with 0x3C
        push_wait(8'h96, PAR_NONE, 1'b0);
        repeat (5) step(1'b1);
        chk("rst_mid_busy_before", tx_busy, 1'b1);
        rst = 1'b1;
        step(1'b1);
        chk("rst_mid_tx", tx, 1'b1);
        chk("rst_mid_busy", tx_busy, 1'b0);
        chk("rst_mid_ready", in_ready, 1'b0);
        chk("rst_mid_done", last_done, 1'b0);
        step(1'b1);
        rst = 1'b0;
        step(1'b0);
        chk("rst_rel_ready", in_ready, 1'b1);
        chk("rst_rel_tx", tx, 1'b1);
        push_wait(8'h3C, PAR_NONE, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b1);
            if (k == 0) chk("rec_start", tx, 1'b0);
            if (k >= 1 && k <= 8) chk("rec_bit", tx, e1[0] ^ 1'b0 ^ ((8'h3C >> (k - 1)) & 8'h01) != 0);
        end
        step(1'b1);
        chk("rec_done", last_done, 1'b1);

        step(1'b0);
        chk("sb_empty", sb_q.size(), 0);
        chk("src_empty", src_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
